// File: rtl/tqvp_wdt_reset_seq.sv
// Watchdog reset sequencer: turns a watchdog timeout level into a grace-window warning, a timed reset pulse and a hold-off.
// Optional manual reset button on ui_in[3]: define TQVP_WDTSEQ_MANUAL_EN.
module tqvp_wdt_reset_seq #(
  parameter int HOLDOFF_CYCLES  = 256,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  input  logic        wdt_timeout,
  output logic        sys_reset
);

  // Bus handshake: a request is any data_write_n/data_read_n other than 2'b11 in a cycle;
  // writes commit at that clock edge, reads answer with data_ready=1 and data_out one cycle later.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARN    = 2'd1,
    ST_PULSE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLDOFF_LAST = HW'(HOLDOFF_CYCLES - 1);

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_GRACE  = 6'h04;
  localparam logic [5:0] ADDR_PULSE  = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_CLEAR  = 6'h10;

  state_e        state_q, state_d;
  logic [15:0]   grace_cnt_q, grace_cnt_d;
  logic [7:0]    pulse_cnt_q, pulse_cnt_d;
  logic [HW-1:0] holdoff_cnt_q, holdoff_cnt_d;

  logic          arm_q, arm_d;
  logic          polarity_q, polarity_d;
  logic [15:0]   grace_q, grace_d;
  logic [7:0]    pulse_q, pulse_d;
  logic          wdt_cause_q, wdt_cause_d;
  logic          manual_cause_q, manual_cause_d;
  logic [7:0]    reset_count_q, reset_count_d;

  logic          sys_reset_q, sys_reset_d;
  logic          data_ready_q, data_ready_d;
  logic [31:0]   data_out_q, data_out_d;

  logic          wr_en, rd_en;
  logic          clear_hit;
  logic          wdt_hit, manual_hit;
  logic          manual_fire;
  logic [7:0]    pulse_len;
  logic [31:0]   rd_data;
  logic          unused_data;

  assign wr_en     = (data_write_n != 2'b11);
  assign rd_en     = (data_read_n != 2'b11);
  assign clear_hit = wr_en && (address == ADDR_CLEAR) && (data_in[7:0] == 8'h5A);
  assign pulse_len = (pulse_q == 8'd0) ? 8'd1 : pulse_q;
  assign unused_data = ^data_in[31:16];

`ifdef TQVP_WDTSEQ_MANUAL_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_FULL = DW'(DEBOUNCE_CYCLES);

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          unused_ui;

  // Counter saturates at DEB_FULL, so a held button fires once and must be released to re-arm.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!ui_in[3]) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_FULL) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  assign manual_fire = ui_in[3] && (deb_cnt_q == DEB_FULL - DW'(1));
  assign unused_ui   = ^{ui_in[7:4], ui_in[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end
`else
  logic unused_ui;

  assign manual_fire = 1'b0;
  assign unused_ui   = ^ui_in;
`endif

  // Sequencer next state. A manual trigger outranks the watchdog path in IDLE and WARN.
  always_comb begin
    state_d       = state_q;
    grace_cnt_d   = grace_cnt_q;
    pulse_cnt_d   = pulse_cnt_q;
    holdoff_cnt_d = holdoff_cnt_q;
    wdt_hit       = 1'b0;
    manual_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (manual_fire) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = pulse_len;
          manual_hit  = 1'b1;
        end else if (arm_q && wdt_timeout) begin
          state_d     = ST_WARN;
          grace_cnt_d = grace_q;
        end
      end
      ST_WARN: begin
        if (manual_fire) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = pulse_len;
          manual_hit  = 1'b1;
        end else if (!wdt_timeout || !arm_q) begin
          state_d = ST_IDLE;
        end else if (grace_cnt_q == 16'd0) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = pulse_len;
          wdt_hit     = 1'b1;
        end else begin
          grace_cnt_d = grace_cnt_q - 16'd1;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q <= 8'd1) begin
          state_d       = ST_HOLDOFF;
          holdoff_cnt_d = HOLDOFF_LAST;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end
      end
      ST_HOLDOFF: begin
        if (holdoff_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          holdoff_cnt_d = holdoff_cnt_q - HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CLEAR lands before a same-cycle cause update, so a simultaneous expiry leaves count at 1.
  always_comb begin
    wdt_cause_d    = clear_hit ? 1'b0 : wdt_cause_q;
    manual_cause_d = clear_hit ? 1'b0 : manual_cause_q;
    reset_count_d  = clear_hit ? 8'd0 : reset_count_q;
    if (wdt_hit) begin
      wdt_cause_d = 1'b1;
    end
    if (manual_hit) begin
      manual_cause_d = 1'b1;
    end
    if ((wdt_hit || manual_hit) && (reset_count_d != 8'hFF)) begin
      reset_count_d = reset_count_d + 8'd1;
    end
  end

  always_comb begin
    arm_d      = arm_q;
    polarity_d = polarity_q;
    grace_d    = grace_q;
    pulse_d    = pulse_q;
    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          arm_d      = data_in[0];
          polarity_d = data_in[1];
        end
        ADDR_GRACE: grace_d = (data_write_n == 2'b00) ? {8'h00, data_in[7:0]} : data_in[15:0];
        ADDR_PULSE: pulse_d = data_in[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'hFFFF_FFFF;
    case (address)
      ADDR_CTRL:   rd_data = {30'd0, polarity_q, arm_q};
      ADDR_GRACE:  rd_data = {16'd0, grace_q};
      ADDR_PULSE:  rd_data = {24'd0, pulse_q};
      ADDR_STATUS: rd_data = {16'd0, reset_count_q, 4'd0, manual_cause_q, wdt_cause_q, state_q};
      default:     rd_data = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    data_ready_d = rd_en;
    data_out_d   = rd_en ? rd_data : data_out_q;
    sys_reset_d  = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grace_cnt_q    <= 16'd0;
      pulse_cnt_q    <= 8'd0;
      holdoff_cnt_q  <= '0;
      arm_q          <= 1'b0;
      polarity_q     <= 1'b0;
      grace_q        <= 16'h0100;
      pulse_q        <= 8'h10;
      wdt_cause_q    <= 1'b0;
      manual_cause_q <= 1'b0;
      reset_count_q  <= 8'd0;
      sys_reset_q    <= 1'b0;
      data_ready_q   <= 1'b0;
      data_out_q     <= 32'hFFFF_FFFF;
    end else begin
      state_q        <= state_d;
      grace_cnt_q    <= grace_cnt_d;
      pulse_cnt_q    <= pulse_cnt_d;
      holdoff_cnt_q  <= holdoff_cnt_d;
      arm_q          <= arm_d;
      polarity_q     <= polarity_d;
      grace_q        <= grace_d;
      pulse_q        <= pulse_d;
      wdt_cause_q    <= wdt_cause_d;
      manual_cause_q <= manual_cause_d;
      reset_count_q  <= reset_count_d;
      sys_reset_q    <= sys_reset_d;
      data_ready_q   <= data_ready_d;
      data_out_q     <= data_out_d;
    end
  end

  assign sys_reset      = sys_reset_q;
  assign uo_out         = {6'd0, sys_reset_q ^ polarity_q, 1'b0};
  assign user_interrupt = (state_q == ST_WARN);
  assign data_out       = data_out_q;
  assign data_ready     = data_ready_q;

endmodule

// File: tb/tb_tqvp_wdt_reset_seq.sv
// Bench for tqvp_wdt_reset_seq: phase/elapsed-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus and timeout traffic.
module tb_tqvp_wdt_reset_seq;

  localparam int HOLDOFF = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        wdt_timeout;
  logic        sys_reset;

  int n_tests = 0;
  int n_fail  = 0;

  tqvp_wdt_reset_seq dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt), .wdt_timeout(wdt_timeout), .sys_reset(sys_reset)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    ui_in = 8'h00;
    forever begin
      @(negedge clk);
      ui_in = 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0..3 = IDLE/WARN/PULSE/HOLDOFF; each timed phase is a length plus elapsed cycles.
  int          m_state, m_el, m_len, m_count;
  bit          m_valid = 1'b0;
  bit          m_arm, m_pol, m_wcause, m_ready, m_hit, m_clr;
  logic [15:0] m_grace;
  logic [7:0]  m_pulse;
  logic [31:0] m_dout;

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'h00:   return {30'd0, m_pol, m_arm};
      6'h04:   return {16'd0, m_grace};
      6'h08:   return {24'd0, m_pulse};
      6'h0C:   return {16'd0, 8'(m_count), 4'd0, 1'b0, m_wcause, 2'(m_state)};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_state = 0; m_el = 0; m_len = 0;
      m_arm = 1'b0; m_pol = 1'b0; m_grace = 16'h0100; m_pulse = 8'h10;
      m_wcause = 1'b0; m_count = 0; m_ready = 1'b0; m_dout = 32'hFFFF_FFFF;
    end else if (m_valid) begin
      m_hit = 1'b0;
      m_ready = (data_read_n != 2'b11);
      if (m_ready) m_dout = m_read(address);
      case (m_state)
        0: if (m_arm && wdt_timeout) begin
             m_state = 1; m_el = 0; m_len = int'(m_grace) + 1;
           end
        1: if (!wdt_timeout || !m_arm) m_state = 0;
           else if (m_el == m_len - 1) begin
             m_state = 2; m_el = 0; m_len = (m_pulse == 8'd0) ? 1 : int'(m_pulse); m_hit = 1'b1;
           end else m_el++;
        2: if (m_el == m_len - 1) begin
             m_state = 3; m_el = 0; m_len = HOLDOFF;
           end else m_el++;
        default: if (m_el == m_len - 1) m_state = 0; else m_el++;
      endcase
      m_clr = (data_write_n != 2'b11) && (address == 6'h10) && (data_in[7:0] == 8'h5A);
      if (m_clr) begin m_wcause = 1'b0; m_count = 0; end
      if (m_hit) begin m_wcause = 1'b1; if (m_count < 255) m_count++; end
      if (data_write_n != 2'b11) begin
        case (address)
          6'h00: begin m_arm = data_in[0]; m_pol = data_in[1]; end
          6'h04: m_grace = (data_write_n == 2'b00) ? {8'h00, data_in[7:0]} : data_in[15:0];
          6'h08: m_pulse = data_in[7:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("user_interrupt", {31'd0, user_interrupt}, {31'd0, m_state == 1});
      check("sys_reset", {31'd0, sys_reset}, {31'd0, m_state == 2});
      check("uo_out", {24'd0, uo_out}, {24'd0, 6'd0, (m_state == 2) ^ m_pol, 1'b0});
      check("data_ready", {31'd0, data_ready}, {31'd0, m_ready});
      check("data_out", data_out, m_dout);
    end
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d);
    address = a; data_read_n = 2'b10;
    @(negedge clk);
    check("read_latency", {31'd0, data_ready}, 32'd1);
    d = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic read_expect(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    do_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_ui(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = user_interrupt;
    end
    check("wait_user_interrupt", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_sr(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = sys_reset;
    end
    check("wait_sys_reset", {31'd0, seen}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] addr_tab [8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h3F, 6'h02};

  initial begin
    int ui_cnt, sr_cnt, gap;
    bit rewarn, pend;
    logic [31:0] st, d;
    logic [5:0] a;
    logic [1:0] wn;

    rst = 1'b1; address = 6'h00; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11; wdt_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'hFFFF_FFFF);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_uo_out", {24'd0, uo_out}, 32'd0);
    check("rst_sys_reset", {31'd0, sys_reset}, 32'd0);
    check("rst_user_interrupt", {31'd0, user_interrupt}, 32'd0);
    rst = 1'b0;
    read_expect("rst_ctrl", 6'h00, 32'h0);
    read_expect("rst_grace", 6'h04, 32'h0100);
    read_expect("rst_pulse", 6'h08, 32'h10);
    read_expect("rst_status", 6'h0C, 32'h0);

    // Normal expiry: GRACE=4 -> 5 warn cycles, PULSE=3, then 256 holdoff + 1 idle
    do_write(6'h00, 32'h1, 2'b10);
    do_write(6'h04, 32'h4, 2'b10);
    do_write(6'h08, 32'h3, 2'b10);
    wdt_timeout = 1'b1;
    ui_cnt = 0; sr_cnt = 0; gap = 0; rewarn = 1'b0; pend = 1'b0; st = 32'h0;
    for (int i = 0; i < 300 && !rewarn; i++) begin
      @(negedge clk);
      if (pend && data_ready) begin st = data_out; pend = 1'b0; end
      data_read_n = 2'b11;
      if (sys_reset) begin
        sr_cnt++;
        if (sr_cnt == 1) begin
          check("uo_pulse_pol0", {24'd0, uo_out}, 32'h02);
          address = 6'h0C; data_read_n = 2'b10; pend = 1'b1;
        end
      end
      if (user_interrupt) begin
        if (sr_cnt == 0) ui_cnt++; else rewarn = 1'b1;
      end else if (sr_cnt > 0 && !sys_reset) gap++;
    end
    check("expiry_warn_cycles", ui_cnt, 5);
    check("expiry_pulse_cycles", sr_cnt, 3);
    check("expiry_status_in_pulse", st, 32'h0106);
    check("expiry_holdoff_gap", gap, HOLDOFF + 1);
    check("expiry_rewarn", {31'd0, rewarn}, 32'd1);
    wdt_timeout = 1'b0;
    repeat (3) @(negedge clk);

    // Recovery: timeout drops after 6 warn cycles
    do_write(6'h10, 32'h5A, 2'b00);
    do_write(6'h04, 32'd10, 2'b01);
    wdt_timeout = 1'b1;
    wait_ui(10);
    repeat (5) @(negedge clk);
    wdt_timeout = 1'b0;
    sr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sys_reset) sr_cnt++;
    end
    check("recovery_no_pulse", sr_cnt, 0);
    read_expect("recovery_status", 6'h0C, 32'h0);

    // PULSE=0 with polarity=1
    do_write(6'h00, 32'h3, 2'b00);
    do_write(6'h08, 32'hFFFF_FF00, 2'b00);
    do_write(6'h04, 32'h0, 2'b10);
    check("pol_idle_uo", {24'd0, uo_out}, 32'h02);
    wdt_timeout = 1'b1;
    sr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sys_reset) begin
        sr_cnt++;
        check("pol_pulse_uo", {24'd0, uo_out}, 32'h00);
      end
    end
    check("pulse0_len", sr_cnt, 1);
    wdt_timeout = 1'b0;
    repeat (HOLDOFF + 10) @(negedge clk);
    read_expect("pulse0_status", 6'h0C, 32'h0104);

    // CLEAR: wrong key ignored; clear coinciding with WARN->PULSE
    do_write(6'h10, 32'h5B, 2'b10);
    read_expect("clear_5b_status", 6'h0C, 32'h0104);
    do_write(6'h00, 32'h1, 2'b00);
    do_write(6'h04, 32'h2, 2'b00);
    do_write(6'h08, 32'h2, 2'b00);
    wdt_timeout = 1'b1;
    wait_ui(10);
    repeat (2) @(negedge clk);
    do_write(6'h10, 32'h5A, 2'b00);
    check("clear_same_cycle_pulse", {31'd0, sys_reset}, 32'd1);
    wdt_timeout = 1'b0;
    repeat (HOLDOFF + 10) @(negedge clk);
    read_expect("clear_same_cycle_status", 6'h0C, 32'h0104);
    do_write(6'h10, 32'h5A, 2'b00);
    read_expect("clear_5a_status", 6'h0C, 32'h0);

    // Register access widths and unmapped reads
    do_write(6'h00, 32'hFFFF_FFFE, 2'b10);
    read_expect("ctrl_rw", 6'h00, 32'h2);
    do_write(6'h04, 32'hABCD_1234, 2'b10);
    read_expect("grace_32b", 6'h04, 32'h1234);
    do_write(6'h04, 32'hFFFF_FF07, 2'b00);
    read_expect("grace_8b_zext", 6'h04, 32'h0007);
    do_write(6'h04, 32'hFFFF_BEEF, 2'b01);
    read_expect("grace_16b", 6'h04, 32'hBEEF);
    do_write(6'h08, 32'h1234_5678, 2'b10);
    read_expect("pulse_rw", 6'h08, 32'h78);
    read_expect("unmapped_14", 6'h14, 32'hFFFF_FFFF);
    read_expect("clear_reads_ones", 6'h10, 32'hFFFF_FFFF);

    // Reset asserted mid-pulse
    do_write(6'h00, 32'h1, 2'b00);
    do_write(6'h04, 32'h1, 2'b00);
    do_write(6'h08, 32'h8, 2'b00);
    wdt_timeout = 1'b1;
    wait_sr(20);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sys_reset", {31'd0, sys_reset}, 32'd0);
    check("midrst_uo_out", {24'd0, uo_out}, 32'd0);
    check("midrst_data_out", data_out, 32'hFFFF_FFFF);
    rst = 1'b0; wdt_timeout = 1'b0;
    read_expect("midrst_status", 6'h0C, 32'h0);
    read_expect("midrst_grace", 6'h04, 32'h0100);
    read_expect("midrst_pulse", 6'h08, 32'h10);

    // 256 back-to-back expiries saturate reset_count
    do_write(6'h00, 32'h1, 2'b00);
    do_write(6'h04, 32'h0, 2'b00);
    do_write(6'h08, 32'h1, 2'b00);
    wdt_timeout = 1'b1;
    repeat (256 * (HOLDOFF + 3) + 5) @(negedge clk);
    do_read(6'h0C, d);
    check("sat_count", {24'd0, d[15:8]}, 32'hFF);
    check("sat_wdt_cause", {31'd0, d[2]}, 32'd1);
    wdt_timeout = 1'b0;
    repeat (HOLDOFF + 10) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) wdt_timeout = !wdt_timeout;
      data_write_n = 2'b11;
      data_read_n = 2'b11;
      a = addr_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) begin
        wn = 2'($urandom_range(0, 2));
        d = $urandom;
        if (a == 6'h04) begin
          if (wn == 2'b00) d[7:0] = 8'($urandom_range(0, 12));
          else d[15:0] = 16'($urandom_range(0, 12));
        end else if (a == 6'h08) begin
          d[7:0] = 8'($urandom_range(0, 6));
        end else if (a == 6'h10 && $urandom_range(0, 1) == 1) begin
          d[7:0] = 8'h5A;
        end
        address = a; data_in = d; data_write_n = wn;
      end else if ($urandom_range(0, 3) == 0) begin
        address = a; data_read_n = 2'($urandom_range(0, 2));
      end
      @(negedge clk);
    end
    rst = 1'b0; data_write_n = 2'b11; data_read_n = 2'b11; wdt_timeout = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
